// File: rtl/gam_memory_layer_engine.sv
// rtl/gam_memory_layer_engine.sv - GAM memory-layer learn/recall engine with on-chip node storage
// Two-minimum L1 search over stored prototypes, then insert, or update the winner/runner-up and link them.
module gam_memory_layer_engine #(
    parameter int NODES    = 16,
    parameter int DIM      = 4,
    parameter int DATA_W   = 8,
    parameter int CLASS_W  = 4,
    parameter int LR_SHIFT = 1,
    parameter int NB_SHIFT = 2,
    parameter int THR_INIT = 16,
    localparam int IDX_W   = $clog2(NODES),
    localparam int DIST_W  = DATA_W + $clog2(DIM)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DIM*DATA_W-1:0]   in_x,
    input  logic [CLASS_W-1:0]      in_class,
    input  logic                    in_mode,
    output logic                    done,
    output logic                    result_hit,
    output logic [IDX_W-1:0]        result_node,
    output logic [CLASS_W-1:0]      result_class,
    output logic [DIST_W-1:0]       result_dist,
    output logic [IDX_W:0]          node_count,
    output logic                    full,
    output logic                    overflow,
    input  logic [IDX_W-1:0]        edge_a,
    input  logic [IDX_W-1:0]        edge_b,
    output logic                    edge_q
);

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE, S_SEARCH, S_DECIDE, S_INSERT, S_UPD_S1, S_UPD_S2, S_CONNECT, S_DONE
    } state_t;

    state_t                  state_q;
    logic [DIM*DATA_W-1:0]   x_q;
    logic [CLASS_W-1:0]      cls_q;
    logic                    mode_q;
    logic [IDX_W-1:0]        idx_q, s1_q, s2_q, res_node_q;
    logic [DIST_W-1:0]       d1_q, d2_q;
    logic                    s1v_q, s2v_q, res_hit_q;
    logic [IDX_W:0]          node_count_q;
    logic                    overflow_q, done_q, edge_rd_q;
    logic                    result_hit_q;
    logic [IDX_W-1:0]        result_node_q;
    logic [CLASS_W-1:0]      result_class_q;
    logic [DIST_W-1:0]       result_dist_q;

    logic [DIM*DATA_W-1:0]   w_mem   [NODES];
    logic [CLASS_W-1:0]      cls_mem [NODES];
    logic [DIST_W-1:0]       th_mem  [NODES];
    logic [CNT_W-1:0]        m_mem   [NODES];
    logic [NODES-1:0]        edges_q [NODES];

    logic [DIST_W-1:0]       dist_d;
    logic [DIM*DATA_W-1:0]   w_s1_d, w_s2_d;
    logic [DIST_W:0]         thr_sum_d;
    logic                    full_d, last_idx_d, eligible_d;
    logic [IDX_W-1:0]        ins_idx_d;

    function automatic logic [DATA_W-1:0] absdiff(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Moves each element toward x by a floor-shifted signed difference; never leaves [w, x].
    function automatic logic [DIM*DATA_W-1:0] learn_vec(input logic [DIM*DATA_W-1:0] w,
                                                        input logic [DIM*DATA_W-1:0] x,
                                                        input int sh);
        logic [DIM*DATA_W-1:0] r;
        logic signed [DATA_W:0] diff, nv;
        r = '0;
        for (int i = 0; i < DIM; i++) begin
            diff = $signed({1'b0, x[i*DATA_W +: DATA_W]}) - $signed({1'b0, w[i*DATA_W +: DATA_W]});
            nv   = $signed({1'b0, w[i*DATA_W +: DATA_W]}) + (diff >>> sh);
            r[i*DATA_W +: DATA_W] = nv[DATA_W-1:0];
        end
        return r;
    endfunction

    always_comb begin
        dist_d = '0;
        for (int i = 0; i < DIM; i++) begin
            dist_d = dist_d + DIST_W'(absdiff(x_q[i*DATA_W +: DATA_W], w_mem[idx_q][i*DATA_W +: DATA_W]));
        end
    end

    assign w_s1_d     = learn_vec(w_mem[s1_q], x_q, LR_SHIFT);
    assign w_s2_d     = learn_vec(w_mem[s2_q], x_q, LR_SHIFT + NB_SHIFT);
    assign thr_sum_d  = {1'b0, th_mem[s1_q]} + {1'b0, d1_q};
    assign full_d     = (node_count_q == (IDX_W+1)'(NODES));
    assign last_idx_d = (({1'b0, idx_q} + (IDX_W+1)'(1)) == node_count_q);
    assign eligible_d = mode_q || (cls_mem[idx_q] == cls_q);
    assign ins_idx_d  = node_count_q[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            node_count_q   <= '0;
            overflow_q     <= 1'b0;
            done_q         <= 1'b0;
            edge_rd_q      <= 1'b0;
            result_hit_q   <= 1'b0;
            result_node_q  <= '0;
            result_class_q <= '0;
            result_dist_q  <= '0;
            s1v_q          <= 1'b0;
            s2v_q          <= 1'b0;
            res_hit_q      <= 1'b0;
            res_node_q     <= '0;
            for (int n = 0; n < NODES; n++) begin
                edges_q[n] <= '0;
                m_mem[n]   <= '0;
            end
        end else begin
            done_q    <= 1'b0;
            edge_rd_q <= edges_q[edge_a][edge_b];
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        x_q    <= in_x;
                        cls_q  <= in_class;
                        mode_q <= in_mode;
                        idx_q  <= '0;
                        s1_q   <= '0;
                        s2_q   <= '0;
                        d1_q   <= '1;
                        d2_q   <= '1;
                        s1v_q  <= 1'b0;
                        s2v_q  <= 1'b0;
                        state_q <= (node_count_q == '0) ? S_DECIDE : S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    // Strict compares keep the lower index on ties.
                    if (eligible_d) begin
                        if (dist_d < d1_q) begin
                            s2_q  <= s1_q;
                            d2_q  <= d1_q;
                            s2v_q <= s1v_q;
                            s1_q  <= idx_q;
                            d1_q  <= dist_d;
                            s1v_q <= 1'b1;
                        end else if (dist_d < d2_q) begin
                            s2_q  <= idx_q;
                            d2_q  <= dist_d;
                            s2v_q <= 1'b1;
                        end
                    end
                    idx_q <= idx_q + IDX_W'(1);
                    if (last_idx_d) state_q <= S_DECIDE;
                end
                S_DECIDE: begin
                    res_node_q <= s1_q;
                    if (mode_q) begin
                        res_hit_q <= s1v_q;
                        state_q   <= S_DONE;
                    end else if (!s1v_q || (d1_q > th_mem[s1_q])) begin
                        state_q <= S_INSERT;
                    end else begin
                        state_q <= S_UPD_S1;
                    end
                end
                S_INSERT: begin
                    res_hit_q <= 1'b0;
                    if (full_d) begin
                        overflow_q <= 1'b1;
                        res_node_q <= '0;
                    end else begin
                        w_mem[ins_idx_d]   <= x_q;
                        cls_mem[ins_idx_d] <= cls_q;
                        th_mem[ins_idx_d]  <= s1v_q ? d1_q : DIST_W'(THR_INIT);
                        m_mem[ins_idx_d]   <= CNT_W'(1);
                        res_node_q         <= ins_idx_d;
                        node_count_q       <= node_count_q + (IDX_W+1)'(1);
                    end
                    state_q <= S_DONE;
                end
                S_UPD_S1: begin
                    w_mem[s1_q]  <= w_s1_d;
                    th_mem[s1_q] <= thr_sum_d[DIST_W:1];
                    if (m_mem[s1_q] != '1) m_mem[s1_q] <= m_mem[s1_q] + CNT_W'(1);
                    res_hit_q <= 1'b1;
                    state_q   <= s2v_q ? S_UPD_S2 : S_DONE;
                end
                S_UPD_S2: begin
                    w_mem[s2_q] <= w_s2_d;
                    state_q     <= S_CONNECT;
                end
                S_CONNECT: begin
                    edges_q[s1_q][s2_q] <= 1'b1;
                    edges_q[s2_q][s1_q] <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    done_q         <= 1'b1;
                    result_hit_q   <= res_hit_q;
                    result_node_q  <= res_node_q;
                    result_class_q <= cls_mem[res_node_q];
                    result_dist_q  <= d1_q;
                    state_q        <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready     = (state_q == S_IDLE);
    assign done         = done_q;
    assign result_hit   = result_hit_q;
    assign result_node  = result_node_q;
    assign result_class = result_class_q;
    assign result_dist  = result_dist_q;
    assign node_count   = node_count_q;
    assign full         = full_d;
    assign overflow     = overflow_q;
    assign edge_q       = edge_rd_q;

endmodule

// File: tb/tb_gam_memory_layer_engine.sv
// tb/tb_gam_memory_layer_engine.sv - directed bench for gam_memory_layer_engine with a prototype-level model
module tb_gam_memory_layer_engine;

    localparam int NODES  = 2;
    localparam int DIM    = 2;
    localparam int DATA_W = 8;
    localparam int DIST_W = 9;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [3:0]  in_class;
    logic        in_mode;
    logic        done;
    logic        result_hit;
    logic [0:0]  result_node;
    logic [3:0]  result_class;
    logic [8:0]  result_dist;
    logic [1:0]  node_count;
    logic        full;
    logic        overflow;
    logic [0:0]  edge_a;
    logic [0:0]  edge_b;
    logic        edge_q;

    gam_memory_layer_engine #(
        .NODES(2), .DIM(2), .DATA_W(8), .CLASS_W(4),
        .LR_SHIFT(1), .NB_SHIFT(2), .THR_INIT(16)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .in_class(in_class), .in_mode(in_mode),
        .done(done), .result_hit(result_hit), .result_node(result_node),
        .result_class(result_class), .result_dist(result_dist),
        .node_count(node_count), .full(full), .overflow(overflow),
        .edge_a(edge_a), .edge_b(edge_b), .edge_q(edge_q)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Prototype-level model of the node memory.
    int mW [NODES][DIM];
    int mcls [NODES];
    int mth [NODES];
    int mcount = 0;
    int movf = 0;
    int medge [NODES][NODES];

    int pending = 0;
    int acc = 0;
    int lat = 0;
    int e_hit, e_node, e_class, e_dist;
    int last_done = -1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int step_toward(input int w, input int x, input int sh);
        int diff, p;
        diff = x - w;
        p = 1 << sh;
        if (diff >= 0) return w + diff / p;
        return w - ((-diff) + p - 1) / p;
    endfunction

    task automatic model_reset();
        mcount = 0;
        movf = 0;
        pending = 0;
        for (int a = 0; a < NODES; a++)
            for (int b = 0; b < NODES; b++) medge[a][b] = 0;
    endtask

    task automatic model_op(input int x0, input int x1, input int c, input int mode);
        int dv [NODES];
        int el [NODES];
        int s1, s2, d1, c0;
        c0 = mcount;
        for (int n = 0; n < NODES; n++) begin
            el[n] = 0;
            dv[n] = 0;
        end
        for (int n = 0; n < c0; n++) begin
            el[n] = (mode == 1) || (mcls[n] == c);
            dv[n] = iabs(x0 - mW[n][0]) + iabs(x1 - mW[n][1]);
        end
        s1 = -1;
        for (int n = 0; n < c0; n++)
            if (el[n] != 0 && (s1 < 0 || dv[n] < dv[s1])) s1 = n;
        s2 = -1;
        for (int n = 0; n < c0; n++)
            if (el[n] != 0 && n != s1 && (s2 < 0 || dv[n] < dv[s2])) s2 = n;
        d1 = (s1 >= 0) ? dv[s1] : (1 << DIST_W) - 1;
        e_dist = d1;
        if (mode == 1) begin
            e_hit  = (s1 >= 0);
            e_node = (s1 >= 0) ? s1 : 0;
            lat    = c0 + 2;
        end else if (s1 < 0 || d1 > mth[s1]) begin
            e_hit = 0;
            if (c0 == NODES) begin
                movf   = 1;
                e_node = 0;
            end else begin
                e_node      = c0;
                mW[c0][0]   = x0;
                mW[c0][1]   = x1;
                mcls[c0]    = c;
                mth[c0]     = (s1 >= 0) ? d1 : 16;
                mcount      = c0 + 1;
            end
            lat = c0 + 3;
        end else begin
            e_hit  = 1;
            e_node = s1;
            mW[s1][0] = step_toward(mW[s1][0], x0, 1);
            mW[s1][1] = step_toward(mW[s1][1], x1, 1);
            mth[s1]   = (mth[s1] + d1) / 2;
            if (s2 >= 0) begin
                mW[s2][0] = step_toward(mW[s2][0], x0, 3);
                mW[s2][1] = step_toward(mW[s2][1], x1, 3);
                medge[s1][s2] = 1;
                medge[s2][s1] = 1;
                lat = c0 + 5;
            end else begin
                lat = c0 + 3;
            end
        end
        e_class = mcls[e_node];
    endtask

    // Per-cycle comparison against the model while out of reset.
    always @(negedge clk) begin
        if (!reset) begin
            chk("in_ready", in_ready, !(pending != 0 && cyc >= acc && cyc < acc + lat));
            chk("done", done, (pending != 0 && cyc == acc + lat));
            if (pending != 0 && cyc == acc + lat) begin
                last_done = cyc;
                chk("result_hit", result_hit, e_hit);
                chk("result_node", result_node, e_node);
                chk("result_class", result_class, e_class);
                chk("result_dist", result_dist, e_dist);
            end
            if (!(pending != 0 && cyc >= acc && cyc < acc + lat)) begin
                chk("node_count", node_count, mcount);
                chk("full", full, mcount == NODES);
                chk("overflow", overflow, movf);
            end
        end
    end

    task automatic issue(input int x0, input int x1, input int c, input int mode);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t == 50) chk("ready_timeout", 0, 1);
        #1;
        in_valid = 1'b1;
        in_x     = {8'(x1), 8'(x0)};
        in_class = 4'(c);
        in_mode  = mode[0];
        model_op(x0, x1, c, mode);
        acc = cyc + 1;
        pending = 1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic finish_op();
        while (cyc < acc + lat) @(negedge clk);
        #2;
    endtask

    task automatic op(input int x0, input int x1, input int c, input int mode);
        issue(x0, x1, c, mode);
        finish_op();
    endtask

    task automatic edge_check(input string name, input int a, input int b, input int lit);
        @(negedge clk);
        #1;
        edge_a = 1'(a);
        edge_b = 1'(b);
        @(negedge clk);
        chk(name, edge_q, medge[a][b]);
        chk({name, "_lit"}, edge_q, lit);
    endtask

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_x = '0;
        in_class = '0;
        in_mode = 1'b0;
        edge_a = '0;
        edge_b = '0;
        model_reset();
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_node_count", node_count, 0);
        chk("rst_full", full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_result_hit", result_hit, 0);
        chk("rst_result_node", result_node, 0);
        chk("rst_result_class", result_class, 0);
        chk("rst_result_dist", result_dist, 0);
        chk("rst_edge_q", edge_q, 0);

        // A: insert into empty memory
        op(10, 10, 1, 0);
        chk("A_latency", last_done - acc, 3);
        chk("A_hit", result_hit, 0);
        chk("A_node", result_node, 0);
        chk("A_count", node_count, 1);
        chk("A_model_th0", mth[0], 16);

        // B: update node 0, no runner-up
        op(14, 10, 1, 0);
        chk("B_hit", result_hit, 1);
        chk("B_dist", result_dist, 4);
        chk("B_model_w0", mW[0][0] * 1000 + mW[0][1], 12010);
        chk("B_model_th0", mth[0], 10);
        edge_check("B_edge01", 0, 1, 0);

        // C: far sample inserts node 1, memory now full
        op(100, 100, 1, 0);
        chk("C_node", result_node, 1);
        chk("C_dist", result_dist, 178);
        chk("C_full", full, 1);
        chk("C_model_th1", mth[1], 178);

        // D: winner 0, runner-up 1, connect
        op(12, 11, 1, 0);
        chk("D_latency", last_done - acc, 7);
        chk("D_node", result_node, 0);
        chk("D_dist", result_dist, 1);
        chk("D_hit", result_hit, 1);
        chk("D_model_w0", mW[0][0] * 1000 + mW[0][1], 12010);
        chk("D_model_w1", mW[1][0] * 1000 + mW[1][1], 89088);
        chk("D_model_th0", mth[0], 5);
        edge_check("D_edge01", 0, 1, 1);
        edge_check("D_edge10", 1, 0, 1);
        edge_check("D_edge00", 0, 0, 0);

        // E: recall, with a stray in_valid while busy that must be ignored
        issue(90, 90, 0, 1);
        @(negedge clk);
        #1;
        in_valid = 1'b1;
        in_x = 16'h3030;
        in_mode = 1'b0;
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        finish_op();
        chk("E_latency", last_done - acc, 4);
        chk("E_node", result_node, 1);
        chk("E_class", result_class, 1);
        chk("E_dist", result_dist, 3);
        chk("E_hit", result_hit, 1);
        chk("E_count", node_count, 2);

        // F: new class while full -> overflow
        op(200, 0, 2, 0);
        chk("F_overflow", overflow, 1);
        chk("F_hit", result_hit, 0);
        chk("F_node", result_node, 0);
        chk("F_count", node_count, 2);

        // G: reset during SEARCH aborts without done
        issue(50, 50, 1, 0);
        @(negedge clk);
        #1 reset = 1'b1;
        model_reset();
        @(negedge clk);
        #1 reset = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        chk("G_count", node_count, 0);
        chk("G_overflow", overflow, 0);
        chk("G_full", full, 0);
        edge_check("G_edge01", 0, 1, 0);
        edge_check("G_edge10", 1, 0, 0);

        // H: memory works again after abort
        op(7, 9, 3, 0);
        chk("H_latency", last_done - acc, 3);
        chk("H_node", result_node, 0);
        chk("H_class", result_class, 3);
        chk("H_count", node_count, 1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
